// File: rtl/w_align_engine.sv
// AXI4 W-channel engine: realigns a packed FIFO byte stream to a destination
// byte offset and emits W beats in 4 KiB / max-AWLEN bursts, gated by AW credits.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_start, i_start_addr, i_btt      command (sampled only when idle)
//   i_mode, i_pattern                 fill mode: 0 FIFO data, 1/3 zero, 2 pattern
//   i_aw_issued                       one AW burst address issued (credit +1)
//   o_busy, o_done, o_new_transaction status
//   o_wdata..o_wvalid, i_wready       AXI4 W channel (master)
//   i_fifo_data, i_fifo_empty,
//   o_fifo_read                       first-word-fall-through data FIFO read port
module w_align_engine #(
    parameter int AXI_DATA_WIDTH      = 64,
    parameter int AXI_MAX_AWLEN       = 255,
    parameter int INTERNAL_ADDR_WIDTH = 32,
    parameter int BTT_WIDTH           = 23,
    parameter int MAX_OUTSTANDING_AW  = 4,
    parameter int USE_AW_CREDIT       = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [INTERNAL_ADDR_WIDTH-1:0] i_start_addr,
    input  logic [BTT_WIDTH-1:0]           i_btt,
    input  logic [1:0]                     i_mode,
    input  logic [AXI_DATA_WIDTH-1:0]      i_pattern,
    input  logic                           i_aw_issued,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_new_transaction,
    output logic [AXI_DATA_WIDTH-1:0]      o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]    o_wstrb,
    output logic                           o_wlast,
    output logic                           o_wvalid,
    input  logic                           i_wready,
    input  logic [AXI_DATA_WIDTH-1:0]      i_fifo_data,
    input  logic                           i_fifo_empty,
    output logic                           o_fifo_read
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int CW    = BTT_WIDTH + 1;
    localparam int KB    = 4096 / BYTES;
    localparam int KLB   = $clog2(KB);
    localparam int BAW   = INTERNAL_ADDR_WIDTH - LB;
    localparam int CRW   = $clog2(MAX_OUTSTANDING_AW + 1);
    localparam logic [CW-1:0]    MAXB = CW'(AXI_MAX_AWLEN + 1);
    localparam logic [BYTES-1:0] ONES = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SEND} state_t;

    state_t                    r_state, w_state_n;
    logic                      r_done, w_done_n;
    logic [LB-1:0]             r_off;
    logic [BYTES-1:0]          r_first_mask, r_last_mask;
    logic [1:0]                r_mode;
    logic [BAW-1:0]            r_baddr;
    logic [CW-1:0]             r_beats_left, r_words_left, r_burst_left;
    logic                      r_first;
    logic [AXI_DATA_WIDTH-1:0] r_res, r_wdata;
    logic [BYTES-1:0]          r_wstrb;
    logic                      r_wlast, r_wvalid;
    logic [CRW-1:0]            r_credit;

    logic [LB-1:0]             w_off, w_end;
    logic [CW-1:0]             w_to4k, w_min1, w_burst_len, w_load_left;
    logic                      w_hs, w_last_hs, w_credit_ok, w_go, w_dec;
    logic                      w_residue_beat, w_src_ok, w_load, w_read;
    logic [LB+2:0]             w_sh;
    logic [AXI_DATA_WIDTH-1:0] w_word, w_shifted, w_beat_data;
    logic [BYTES-1:0]          w_beat_strb;

    assign w_off = i_start_addr[LB-1:0];
    assign w_end = w_off + i_btt[LB-1:0];

    assign w_hs      = r_wvalid & i_wready;
    assign w_last_hs = w_hs & r_wlast;

    // Burst length mirrors the AW engine's split rule.
    assign w_to4k      = CW'(KB) - CW'(r_baddr[KLB-1:0]);
    assign w_min1      = (r_beats_left < MAXB) ? r_beats_left : MAXB;
    assign w_burst_len = (w_min1 < w_to4k) ? w_min1 : w_to4k;

    assign w_credit_ok = (USE_AW_CREDIT == 0) || (r_credit != '0);
    assign w_go        = (r_state == S_SETUP) && w_credit_ok;
    assign w_dec       = w_go && (USE_AW_CREDIT != 0);

    // The first beat of a burst is loaded in the SETUP->SEND cycle itself.
    assign w_load_left    = (r_state == S_SETUP) ? w_burst_len : r_burst_left;
    assign w_residue_beat = (r_words_left == '0);
    assign w_src_ok       = (r_mode != 2'd0) || !i_fifo_empty || w_residue_beat;
    assign w_load = !i_rst && (w_go || r_state == S_SEND)
                    && (w_load_left != '0) && (!r_wvalid || i_wready)
                    && w_src_ok;
    assign w_read = w_load && (r_mode == 2'd0) && !w_residue_beat;

    assign w_word = w_residue_beat ? '0 : i_fifo_data;
    assign w_sh   = {r_off, 3'b000};

    always_comb begin
        w_shifted = w_word;
        if (r_off != '0)
            w_shifted = (w_word << w_sh)
                      | (r_res >> (AXI_DATA_WIDTH - int'(w_sh)));
    end

    always_comb begin
        w_beat_data = '0;
        unique case (r_mode)
            2'd0:    w_beat_data = w_shifted;
            2'd2:    w_beat_data = i_pattern;
            default: w_beat_data = '0;
        endcase
    end

    assign w_beat_strb = (r_first ? r_first_mask : ONES)
                       & ((r_beats_left == CW'(1)) ? r_last_mask : ONES);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_done  <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_done_n  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_btt != '0) w_state_n = S_SETUP;
                    else             w_done_n  = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_credit_ok) w_state_n = S_SEND;
            end
            S_SEND: begin
                if (w_last_hs) begin
                    if (r_beats_left != '0) begin
                        w_state_n = S_SETUP;
                    end else begin
                        w_state_n = S_IDLE;
                        w_done_n  = 1'b1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_off        <= '0;
            r_first_mask <= '0;
            r_last_mask  <= '0;
            r_mode       <= '0;
            r_baddr      <= '0;
            r_beats_left <= '0;
            r_words_left <= '0;
            r_burst_left <= '0;
            r_first      <= 1'b0;
            r_res        <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wlast      <= 1'b0;
            r_wvalid     <= 1'b0;
            r_credit     <= '0;
        end else begin
            if (i_aw_issued && !w_dec && r_credit < CRW'(MAX_OUTSTANDING_AW))
                r_credit <= r_credit + CRW'(1);
            else if (w_dec && !i_aw_issued && r_credit != '0)
                r_credit <= r_credit - CRW'(1);

            if (r_state == S_IDLE && i_start) begin
                r_off        <= w_off;
                r_first_mask <= ONES << w_off;
                r_last_mask  <= (w_end == '0) ? ONES : ~(ONES << w_end);
                r_mode       <= (i_mode == 2'd3) ? 2'd1 : i_mode;
                r_baddr      <= i_start_addr[INTERNAL_ADDR_WIDTH-1:LB];
                r_beats_left <= (CW'(i_btt) + CW'(w_off) + CW'(BYTES - 1)) >> LB;
                r_words_left <= (CW'(i_btt) + CW'(BYTES - 1)) >> LB;
                r_first      <= 1'b1;
                r_res        <= '0;
            end

            if (w_go)
                r_baddr <= r_baddr + BAW'(w_burst_len);
            if (w_go || w_load)
                r_burst_left <= w_load_left - CW'(w_load);

            if (w_load) begin
                r_beats_left <= r_beats_left - CW'(1);
                r_first      <= 1'b0;
                r_wdata      <= w_beat_data;
                r_wstrb      <= w_beat_strb;
                r_wlast      <= (w_load_left == CW'(1));
                r_wvalid     <= 1'b1;
                if (w_read) begin
                    r_words_left <= r_words_left - CW'(1);
                    r_res        <= i_fifo_data;
                end
            end else if (w_hs) begin
                r_wvalid <= 1'b0;
            end
        end
    end

    assign o_busy            = (r_state != S_IDLE);
    assign o_done            = r_done;
    assign o_new_transaction = w_last_hs & ~i_rst;
    assign o_wdata           = r_wdata;
    assign o_wstrb           = r_wstrb;
    assign o_wlast           = r_wlast;
    assign o_wvalid          = r_wvalid;
    assign o_fifo_read       = w_read;
endmodule

// File: tb/tb_w_align_engine.sv
// Self-checking bench for w_align_engine: directed scenarios plus randomized
// transfers scored against a byte-level reference model.
module tb_w_align_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [22:0] btt = '0;
    logic [1:0]  mode = '0;
    logic [63:0] pattern = '0;
    logic        aw_issued = 1'b0;
    logic        busy, done, nt;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid;
    logic        wready = 1'b1;
    logic [63:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read;

    w_align_engine dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_start_addr(start_addr), .i_btt(btt), .i_mode(mode),
        .i_pattern(pattern), .i_aw_issued(aw_issued),
        .o_busy(busy), .o_done(done), .o_new_transaction(nt),
        .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
        .o_wvalid(wvalid), .i_wready(wready),
        .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty),
        .o_fifo_read(fifo_read)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model (first-word-fall-through)
    logic [63:0] fq[$];
    bit hold_empty = 1'b0;
    bit rd_s;
    always begin
        @(negedge clk);
        rd_s = fifo_read;
        @(posedge clk);
        #2;
        if (rd_s && fq.size() > 0) void'(fq.pop_front());
        fifo_empty = hold_empty || (fq.size() == 0);
        fifo_data  = (fq.size() > 0) ? fq[0] : 64'd0;
    end

    // W channel monitor
    logic [63:0] cap_data[$];
    logic [7:0]  cap_strb[$];
    logic        cap_last[$];
    int          cap_cyc[$];
    int nt_cnt = 0, done_cnt = 0, done_cyc = 0, rd_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (wvalid && wready) begin
                cap_data.push_back(wdata);
                cap_strb.push_back(wstrb);
                cap_last.push_back(wlast);
                cap_cyc.push_back(cyc);
            end
            if (nt) nt_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fifo_read) begin
                rd_cnt++;
                checks++;
                if (fifo_empty) begin
                    errors++;
                    $display("FAIL fifo_read_empty: read=1 empty=%b need empty=0",
                             fifo_empty);
                end
            end
        end
    end

    // Reference model: expected beats from byte addresses
    logic [7:0]  stream[$];
    logic [63:0] exp_data[$];
    logic [7:0]  exp_strb[$];
    logic        exp_last[$];
    int exp_words, cur_mode, start_cyc;
    int rd_base, done_base, nt_base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [31:0] a, input int n,
                         input logic [1:0] m, input logic [63:0] pat);
        int o, nb, cnt, i;
        logic [31:0] ba;
        logic [63:0] d;
        logic [7:0]  s;
        logic        lst;
        o  = int'(a[2:0]);
        nb = (n + o + 7) / 8;
        cnt = 0;
        exp_data.delete();
        exp_strb.delete();
        exp_last.delete();
        for (int b = 0; b < nb; b++) begin
            d = '0;
            s = '0;
            for (int l = 0; l < 8; l++) begin
                i = b * 8 + l - o;
                if (i >= 0 && i < n) begin
                    s[l] = 1'b1;
                    if (m == 2'd0) d[8*l +: 8] = stream[i];
                end
            end
            if (m == 2'd2) d = pat;
            cnt++;
            ba  = (a & ~32'h7) + 32'(b * 8);
            lst = (b == nb - 1) || (cnt == 256)
                  || (((ba + 32'd8) & 32'hFFF) == 32'd0);
            if (lst) cnt = 0;
            exp_data.push_back(d);
            exp_strb.push_back(s);
            exp_last.push_back(lst);
        end
    endtask

    task automatic launch(input logic [31:0] a, input int n,
                          input logic [1:0] m, input logic [63:0] pat,
                          input bit seq, input int npush);
        logic [63:0] w;
        int nw;
        stream.delete();
        for (int i = 0; i < n; i++)
            stream.push_back(seq ? 8'(i) : 8'($urandom));
        nw = (n + 7) / 8;
        exp_words = (m == 2'd0) ? nw : 0;
        if (m == 2'd0) begin
            for (int k = 0; k < nw; k++) begin
                if (npush < 0 || k < npush) begin
                    w = '0;
                    for (int l = 0; l < 8; l++)
                        if (8 * k + l < n) w[8*l +: 8] = stream[8*k + l];
                    fq.push_back(w);
                end
            end
        end
        model(a, n, m, pat);
        cur_mode = int'(m);
        cap_data.delete();
        cap_strb.delete();
        cap_last.delete();
        cap_cyc.delete();
        rd_base   = rd_cnt;
        done_base = done_cnt;
        nt_base   = nt_cnt;
        start_addr = a;
        btt        = 23'(n);
        mode       = m;
        pattern    = pat;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit rnd, input bit aw_all);
        for (int k = 0; k < limit && done_cnt == done_base; k++) begin
            wready     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            hold_empty = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
            aw_issued  = aw_all;
            tick();
        end
        wready     = 1'b1;
        hold_empty = 1'b0;
        aw_issued  = 1'b0;
        tick();
        tick();
        checks++;
        if (done_cnt == done_base) begin
            errors++;
            $display("FAIL done_timeout: done pulses %0d need %0d",
                     done_cnt - done_base, 1);
        end
    endtask

    task automatic score();
        logic [63:0] mk;
        int nmin;
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL beat_count: got %0d need %0d",
                     cap_data.size(), exp_data.size());
        end
        nmin = (cap_data.size() < exp_data.size()) ? cap_data.size()
                                                   : exp_data.size();
        for (int i = 0; i < nmin; i++) begin
            mk = '1;
            if (cur_mode == 0)
                for (int l = 0; l < 8; l++)
                    mk[8*l +: 8] = exp_strb[i][l] ? 8'hFF : 8'h00;
            checks++;
            if ((cap_data[i] & mk) !== exp_data[i] || cap_strb[i] !== exp_strb[i]
                || cap_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL beat%0d: data %h strb %h last %b need %h %h %b",
                         i, cap_data[i] & mk, cap_strb[i], cap_last[i],
                         exp_data[i], exp_strb[i], exp_last[i]);
            end
        end
        checks++;
        if (rd_cnt - rd_base != exp_words) begin
            errors++;
            $display("FAIL fifo_reads: got %0d need %0d", rd_cnt - rd_base, exp_words);
        end
    endtask

    task automatic credit(input int n);
        repeat (n) begin
            aw_issued = 1'b1;
            tick();
        end
        aw_issued = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wvalid, wlast, wstrb, fifo_read, busy, done, nt} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: vld %b last %b strb %h rd %b busy %b done %b nt %b need 0",
                     wvalid, wlast, wstrb, fifo_read, busy, done, nt);
        end
        tick();
    endtask

    task automatic test_btt_zero();
        start_addr = 32'h100;
        btt = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL btt_zero: done %b busy %b need 1 0", done, busy);
        end
        tick();
    endtask

    task automatic test_misaligned();
        credit(1);
        launch(32'h1003, 10, 2'd0, '0, 1'b1, -1);
        wait_done(100, 1'b0, 1'b0);
        score();
        checks++;
        if (cap_strb.size() != 2 || cap_strb[0] !== 8'hF8 || cap_strb[1] !== 8'h1F
            || cap_data[0][63:24] !== 40'h0403020100
            || cap_data[1][39:0] !== 40'h0908070605 || cap_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_beats: n %0d need 2 strb/data/last mismatch",
                     cap_strb.size());
        end
        checks++;
        if (cap_cyc.size() < 2 || cap_cyc[0] != start_cyc + 2) begin
            errors++;
            $display("FAIL first_wvalid_latency: cyc %0d need %0d",
                     cap_cyc.size() ? cap_cyc[0] : -1, start_cyc + 2);
        end
        checks++;
        if (cap_cyc.size() < 2 || done_cyc != cap_cyc[1] + 1) begin
            errors++;
            $display("FAIL done_timing: cyc %0d need last hs + 1", done_cyc);
        end
    endtask

    task automatic test_residue();
        credit(1);
        launch(32'h5, 8, 2'd0, '0, 1'b1, -1);
        wait_done(100, 1'b0, 1'b0);
        score();
        checks++;
        if (cap_strb.size() != 2 || cap_strb[0] !== 8'hE0 || cap_strb[1] !== 8'h1F
            || cap_data[1][39:0] !== 40'h0706050403) begin
            errors++;
            $display("FAIL residue_beat: n %0d need 2 with strb E0/1F",
                     cap_strb.size());
        end
    endtask

    task automatic test_4k_split();
        credit(2);
        launch(32'h0FF8, 24, 2'd0, '0, 1'b0, -1);
        wait_done(100, 1'b0, 1'b0);
        score();
        checks++;
        if (cap_last.size() != 3
            || {cap_last[0], cap_last[1], cap_last[2]} !== 3'b101) begin
            errors++;
            $display("FAIL split_wlast: n %0d need 3 beats wlast 101", cap_last.size());
        end
        checks++;
        if (nt_cnt - nt_base != 2) begin
            errors++;
            $display("FAIL split_new_txn: got %0d need 2", nt_cnt - nt_base);
        end
        checks++;
        if (cap_cyc.size() != 3 || cap_cyc[1] - cap_cyc[0] != 2
            || cap_cyc[2] - cap_cyc[1] != 1) begin
            errors++;
            $display("FAIL split_bubble: beat spacing wrong need gaps 2 and 1");
        end
    endtask

    task automatic test_credit_gate();
        launch(32'h0, 2400, 2'd0, '0, 1'b0, -1);
        repeat (20) tick();
        checks++;
        if (cap_data.size() != 0 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL credit_gate_idle: beats %0d wvalid %b need 0 0",
                     cap_data.size(), wvalid);
        end
        credit(1);
        for (int k = 0; k < 400 && cap_data.size() < 256; k++) tick();
        repeat (20) tick();
        checks++;
        if (cap_data.size() != 256 || busy !== 1'b1) begin
            errors++;
            $display("FAIL credit_gate_burst1: beats %0d busy %b need 256 1",
                     cap_data.size(), busy);
        end
        credit(1);
        wait_done(200, 1'b0, 1'b0);
        score();
        checks++;
        if (cap_last.size() != 300 || cap_last[255] !== 1'b1
            || cap_last[299] !== 1'b1) begin
            errors++;
            $display("FAIL credit_gate_split: beats %0d need 256+44",
                     cap_last.size());
        end
    endtask

    task automatic test_fill_modes();
        for (int p = 0; p < 2; p++) begin
            credit(1);
            launch(32'h4, 16, p ? 2'd2 : 2'd1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, -1);
            wait_done(100, 1'b0, 1'b0);
            score();
            checks++;
            if (cap_strb.size() != 3 || cap_strb[0] !== 8'hF0
                || cap_strb[1] !== 8'hFF || cap_strb[2] !== 8'h0F
                || cap_data[1] !== (p ? 64'hA5A5_A5A5_A5A5_A5A5 : 64'd0)) begin
                errors++;
                $display("FAIL fill_mode%0d: n %0d need 3 strb F0/FF/0F",
                         p + 1, cap_strb.size());
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int n;
        for (int t = 0; t < 25; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
            n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 16)
                                            : $urandom_range(1, 400);
            aw_issued = 1'b1;
            launch(a, n, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b0, -1);
            wait_done(1500, 1'b1, 1'b1);
            score();
        end
    endtask

    task automatic test_backpressure_reset();
        logic [63:0] sd;
        logic [7:0]  ss;
        logic        sl;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fq.delete();
        tick();
        credit(1);
        wready = 1'b0;
        launch(32'h0, 64, 2'd0, '0, 1'b0, 3);
        for (int k = 0; k < 10 && !wvalid; k++) tick();
        wready = 1'b1;
        tick();
        tick();
        wready = 1'b0;
        @(negedge clk);
        sd = wdata;
        ss = wstrb;
        sl = wlast;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (wvalid !== 1'b1 || wdata !== sd || wstrb !== ss || wlast !== sl) begin
                errors++;
                $display("FAIL hold_stable: vld %b data %h strb %h last %b need 1 %h %h %b",
                         wvalid, wdata, wstrb, wlast, sd, ss, sl);
            end
        end
        tick();
        wready = 1'b1;
        tick();
        wready = 1'b0;
        @(negedge clk);
        checks++;
        if (wvalid !== 1'b0 || busy !== 1'b1 || cap_data.size() != 3) begin
            errors++;
            $display("FAIL underrun_drop: vld %b busy %b beats %0d need 0 1 3",
                     wvalid, busy, cap_data.size());
        end
        tick();
        fq.push_back({$urandom, $urandom});
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (wvalid !== 1'b1) begin
            errors++;
            $display("FAIL underrun_resume: vld %b need 1", wvalid);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: vld %b busy %b need 0 0", wvalid, busy);
        end
        tick();
        fq.delete();
        wready = 1'b1;
        launch(32'h0, 16, 2'd0, '0, 1'b0, -1);
        repeat (15) tick();
        checks++;
        if (cap_data.size() != 0 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_credit: beats %0d vld %b need 0 0",
                     cap_data.size(), wvalid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fq.delete();
        tick();
    endtask

    initial begin
        test_reset();
        test_btt_zero();
        test_misaligned();
        test_residue();
        test_4k_split();
        test_credit_gate();
        test_fill_modes();
        test_random();
        test_backpressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/w_align_engine.md
# w_align_engine

Parametrised AXI4 write-data engine, successor to the single-mode W engine in the DMA write path. Takes a packed byte stream from the data FIFO, realigns it to an arbitrary destination byte offset, and emits W beats. Bursts are split on 4 KiB and max-AWLEN boundaries. Three fill modes are supported (FIFO data, zero, constant pattern). Coupling to the AW engine uses a multi-burst credit counter instead of a single sync flag.

## Interface
- AXI_DATA_WIDTH, 64: W data width in bits, power of two ≥ 32; BYTES = AXI_DATA_WIDTH/8, LB = log2(BYTES).
- AXI_MAX_AWLEN, 255: maximum AWLEN value; a burst has at most AXI_MAX_AWLEN+1 beats.
- INTERNAL_ADDR_WIDTH, 32: start address width.
- BTT_WIDTH, 23: bytes-to-transfer width.
- MAX_OUTSTANDING_AW, 4: credit counter saturation value.
- USE_AW_CREDIT, 1: 1 = a burst starts only with a credit; 0 = credits ignored.
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  command pulse, sampled only in IDLE.
- start_addr  in  INTERNAL_ADDR_WIDTH  destination byte address.
- btt  in  BTT_WIDTH  bytes to write.
- mode  in  2  0 data, 1 zero, 2 pattern (3 treated as 1).
- pattern  in  AXI_DATA_WIDTH  fill word for mode 2; must stay stable while busy.
- aw_issued  in  1  pulse: AW engine issued one burst address.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the final beat handshake.
- new_transaction  out  1  high in the cycle of each wlast handshake.
- w_chan  AXI4_W.master  wdata/wstrb/wlast/wvalid/wready.
- data_fifo  FIFO_READ.master  data (AXI_DATA_WIDTH), empty, read (first-word-fall-through).

## Operation
- Let o = start_addr[LB-1:0].
  - Beats = ceil((btt+o)/BYTES).
  - FIFO words = ceil(btt/BYTES); data mode only.
  - Byte 0 of the stream sits in lane 0 of the first FIFO word.
- Realignment: beat k = (word_k << 8·o) | (word_{k-1} >> 8·(BYTES−o)), using a residue register.
  - If beats > words, the final beat is built from the residue only, with no FIFO read.
  - o = 0 is a pure pass-through.
- wstrb:
  - First beat: lanes ≥ o.
  - Last beat: lanes < (o+btt) mod BYTES, or all lanes if that value is 0.
  - Single-beat transfer: AND of both masks.
  - All other beats: all ones.
- Zero and pattern modes: wdata = 0 or pattern, not shifted. data_fifo.read is never asserted. wstrb follows the same rules.
- Burst length = min(remaining beats, AXI_MAX_AWLEN+1, beats to the next 4 KiB boundary from the current beat-aligned address). This matches the AW engine's split exactly.
- Credits:
  - Counter increments on aw_issued and decrements at each SETUP→SEND transition.
  - Simultaneous increment and decrement leaves it unchanged.
  - Saturates at MAX_OUTSTANDING_AW and at 0.
  - Credits arriving while IDLE are kept.
- States:
  - IDLE: on start with btt ≠ 0 → SETUP; on start with btt = 0 → done pulse next cycle, state stays IDLE.
  - SETUP: compute burst length and beat counter; → SEND when a credit is available (or USE_AW_CREDIT = 0).
  - SEND: wvalid is high whenever a beat is held.
    - Refill is possible when the output register is empty or handshaking, and the next source beat is available (mode ≠ 0, FIFO not empty, or residue-only beat).
    - On the wlast handshake: → SETUP if beats remain, else → IDLE with done.
- AXI rule: once wvalid is high, wdata, wstrb and wlast hold stable until wready.

## Timing
- Reset values: wvalid 0, wlast 0, wstrb 0, data_fifo.read 0, busy 0, done 0, new_transaction 0, credit 0, state IDLE.
- Reset mid-transfer aborts at once. No further beats are sent; the FIFO is not drained.
- Latency: start at cycle 0 → SETUP at cycle 1 → first wvalid at cycle 2, given a credit and a non-empty FIFO.
- Throughput: one beat per cycle within a burst, and exactly one SETUP bubble cycle between bursts.
- FIFO underrun mid-burst: wvalid drops after the held beat handshakes; no gap is inserted inside a held beat.
- data_fifo.read is asserted only in the cycle a word is consumed into the output/residue path. It is never asserted when empty is high.

## Test plan
- Misaligned data write, 64-bit bus: start_addr 0x1003, btt 10, FIFO words bytes 00..0F.
  - 2 beats: wstrb 0xF8 then 0x1F.
  - Lanes 3–7 carry 00..04, then lanes 0–4 carry 05..09.
  - wlast on beat 2; 2 FIFO reads; done one cycle later.
- Residue beat: start_addr 0x5, btt 8.
  - 2 beats (wstrb 0xE0, 0x1F) from 1 FIFO read.
- 4 KiB split: start_addr 0x0FF8, btt 24, credits preloaded to 2.
  - Bursts of 1 and 2 beats; wlast on beats 1 and 3; new_transaction pulses twice; one bubble cycle between bursts.
- Credit gating, max-len split: start_addr 0, btt 2400, USE_AW_CREDIT = 1, no aw_issued.
  - wvalid stays 0.
  - One aw_issued pulse → 256-beat burst, then stall.
  - Second pulse → 44-beat burst.
- Zero mode: start_addr 0x4, btt 16.
  - 3 beats, wdata 0, wstrb 0xF0/0xFF/0x0F, data_fifo.read never high.
  - Repeat in mode 2 with pattern 0xA5A5…: same strobes, wdata = pattern.
- Backpressure and reset: hold wready low for 5 cycles with the FIFO empty mid-burst.
  - wdata, wstrb and wlast stay stable while wready is low.
  - Assert rst mid-burst → next cycle wvalid 0, busy 0, credit 0.
